// File: rtl/sensor_pkg.sv
// Shared types and widths for the sensor capture path (packer and FIFO).
package sensor_pkg;

  localparam int unsigned SENSOR_WORD_WIDTH   = 32;
  localparam int unsigned SENSOR_SAMPLE_WIDTH = 16;
  localparam logic        PAD_VALUE           = 1'b0;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_WAIT = 1'b1
  } packer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sensor_word_packer.sv
// Packs narrow sensor samples LSB-first into FIFO words, with flush/zero-pad
// and a saturating count of samples dropped while the output path is blocked.
module sensor_word_packer
  import sensor_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH   = SENSOR_SAMPLE_WIDTH,
  parameter int unsigned WORD_WIDTH     = SENSOR_WORD_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]   sample_data,
  input  logic                      flush,
  input  logic                      fifo_full,
  output logic                      sample_ready,
  output logic                      write_command,
  output logic [WORD_WIDTH-1:0]     write_data,
  output logic                      flush_done,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      overflow
);

  localparam int unsigned          LANES     = WORD_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned          LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [WORD_WIDTH-1:0] PAD_WORD = {WORD_WIDTH{PAD_VALUE}};

  packer_state_t         state;
  logic [LANE_W-1:0]     lane_cnt;
  logic [WORD_WIDTH-1:0] asm_reg;
  logic                  out_pending;

  logic                  drain;
  logic                  out_free;
  logic                  accept;
  logic                  drop;
  logic                  word_done;
  logic [LANE_W-1:0]     lane_next;
  logic [WORD_WIDTH-1:0] asm_next;

  assign write_command = drain;

  // Handshake and post-sample view of the assembly lanes.
  always_comb begin
    drain        = out_pending && !fifo_full;
    out_free     = !out_pending || drain;
    sample_ready = !((lane_cnt == LAST_LANE) && !out_free) && (state != FLUSH_WAIT);
    accept       = sample_valid && sample_ready;
    drop         = sample_valid && !sample_ready;
    word_done    = accept && (lane_cnt == LAST_LANE);
    asm_next     = asm_reg;
    lane_next    = lane_cnt;
    if (accept) begin
      asm_next[32'(lane_cnt) * SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data;
      lane_next = word_done ? '0 : lane_cnt + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      lane_cnt    <= '0;
      asm_reg     <= PAD_WORD;
      out_pending <= 1'b0;
      write_data  <= '0;
      flush_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (drain) begin
        out_pending <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        FILL: begin
          lane_cnt <= lane_next;
          asm_reg  <= word_done ? PAD_WORD : asm_next;
          if (word_done) begin
            write_data  <= asm_next;
            out_pending <= 1'b1;
          end
          // Flush acts on the word including this cycle's sample.
          if (flush) begin
            if (lane_next != '0) begin
              if (out_free) begin
                write_data  <= asm_next;
                out_pending <= 1'b1;
                lane_cnt    <= '0;
                asm_reg     <= PAD_WORD;
                flush_done  <= 1'b1;
              end else begin
                state <= FLUSH_WAIT;
              end
            end else begin
              flush_done <= 1'b1;
            end
          end
        end
        FLUSH_WAIT: begin
          if (out_free) begin
            write_data  <= asm_reg;
            out_pending <= 1'b1;
            lane_cnt    <= '0;
            asm_reg     <= PAD_WORD;
            flush_done  <= 1'b1;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  sat_counter #(
    .WIDTH(DROP_CNT_WIDTH)
  ) u_drop_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (drop),
    .count(drop_count)
  );

endmodule
